// File: rtl/image_reflect_stream.sv
// rtl/image_reflect_stream.sv - frame buffer that re-emits a raster frame reflected vertically, horizontally or both
// Optional REFLECT_FRAME_CNT_EN adds a 16-bit count of completed output frames.
module image_reflect_stream #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 512,
    parameter int COLS   = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_eol,
    output logic              m_last,
    output logic              busy
`ifdef REFLECT_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    localparam int TOTAL = ROWS * COLS;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic [1:0]        mode_q;
    logic              drain_wait;
    logic              fetched_all;
    logic [DATA_W-1:0] mem [TOTAL];

    logic              s_fire, m_fire, fetch, col_end, frame_end;
    logic [RW-1:0]     src_row;
    logic [CW-1:0]     src_col;
    logic [AW-1:0]     wr_addr, rd_addr;

    assign s_fire    = s_valid && s_ready;
    assign m_fire    = m_valid && m_ready;
    assign col_end   = (col == COL_MAX);
    assign frame_end = col_end && (row == ROW_MAX);
    // One counter pair serves both phases: write position in LOAD, output position in DRAIN.
    assign fetch     = (state == DRAIN) && !drain_wait && !fetched_all && (!m_valid || m_ready);
    assign src_row   = mode_q[0] ? (ROW_MAX - row) : row;
    assign src_col   = mode_q[1] ? (COL_MAX - col) : col;
    assign wr_addr   = AW'(row) * AW'(COLS) + AW'(col);
    assign rd_addr   = AW'(src_row) * AW'(COLS) + AW'(src_col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, LOAD: if (s_fire) state_nxt = frame_end ? DRAIN : LOAD;
            DRAIN:      if (m_fire && m_last) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row         <= '0;
            col         <= '0;
            mode_q      <= 2'b00;
            s_ready     <= 1'b0;
            drain_wait  <= 1'b0;
            fetched_all <= 1'b0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_eol       <= 1'b0;
            m_last      <= 1'b0;
        end else begin
            s_ready    <= (state_nxt != DRAIN);
            // The extra idle cycle places the first output two cycles after the final input.
            drain_wait <= s_fire && frame_end;
            if (state == IDLE && s_fire)
                mode_q <= mode;
            if (s_fire && frame_end)
                fetched_all <= 1'b0;
            else if (fetch && frame_end)
                fetched_all <= 1'b1;
            if (s_fire || fetch) begin
                if (col_end) begin
                    col <= '0;
                    row <= (row == ROW_MAX) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (fetch) begin
                m_valid <= 1'b1;
                m_data  <= mem[rd_addr];
                m_eol   <= col_end;
                m_last  <= frame_end;
            end else if (m_fire) begin
                m_valid <= 1'b0;
                m_eol   <= 1'b0;
                m_last  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s_fire)
            mem[wr_addr] <= s_data;
    end

`ifdef REFLECT_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                frame_cnt <= 16'd0;
        else if (m_fire && m_last) frame_cnt <= frame_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_image_reflect_stream.sv
// tb/tb_image_reflect_stream.sv - randomized self-checking bench for image_reflect_stream on a 4x4 frame
module tb_image_reflect_stream;

    localparam int R = 4;
    localparam int C = 4;
    localparam int N = R * C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'd0;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_eol, m_last, busy;
`ifdef REFLECT_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    always #5 clk = ~clk;

    image_reflect_stream #(.DATA_W(8), .ROWS(R), .COLS(C)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_eol(m_eol), .m_last(m_last), .busy(busy)
`ifdef REFLECT_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] in_pix [N];
    logic [7:0] got_data [$];
    bit         got_eol [$];
    bit         got_last [$];
    int lat, unstable, sready_hi, idle_flags;

    // Reference: output (r,c) comes from source (mode[0] ? R-1-r : r, mode[1] ? C-1-c : c).
    function automatic logic [7:0] ref_pix(input logic [1:0] md, input int idx);
        int r, c, sr, sc;
        r  = idx / C;
        c  = idx % C;
        sr = md[0] ? (R - 1 - r) : r;
        sc = md[1] ? (C - 1 - c) : c;
        return in_pix[sr * C + sc];
    endfunction

    task automatic fill_frame(input bit rnd);
        for (int k = 0; k < N; k++) in_pix[k] = rnd ? 8'($urandom) : 8'(k);
    endtask

    task automatic send_frame(input logic [1:0] md, input int gap_pct, input int toggle_after,
                              input logic [1:0] toggle_md);
        for (int k = 0; k < N; k++) begin
            int w;
            @(negedge clk);
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = in_pix[k];
            mode    = (k > toggle_after) ? toggle_md : md;
            w = 0;
            while (!s_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (w >= 50) begin
                checks++; failures++;
                $display("FAIL send_timeout pixel=%0d s_ready=%b required=1", k, s_ready);
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic collect(input int n, input int low_pct);
        logic [7:0] pd;
        bit pe, pl, stalled;
        int cyc;
        got_data.delete(); got_eol.delete(); got_last.delete();
        lat = -1; unstable = 0; sready_hi = 0; idle_flags = 0;
        stalled = 0; cyc = 0; pd = 0; pe = 0; pl = 0;
        while (got_data.size() < n && cyc < 400) begin
            if (cyc > 0) @(negedge clk);
            if (stalled && (!m_valid || m_data !== pd || m_eol !== pe || m_last !== pl)) unstable++;
            if (!m_valid && (m_eol || m_last)) idle_flags++;
            if (s_ready) sready_hi++;
            if (m_valid && lat < 0) lat = cyc;
            m_ready = ($urandom_range(99) >= low_pct);
            stalled = m_valid && !m_ready;
            pd = m_data; pe = m_eol; pl = m_last;
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_eol.push_back(m_eol);
                got_last.push_back(m_last);
            end
            cyc++;
        end
        if (got_data.size() < n) begin
            checks++; failures++;
            $display("FAIL collect_timeout got=%0d required=%0d", got_data.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_ready, m_valid, m_data, m_eol, m_last, busy} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0", {s_ready, m_valid, m_data, m_eol, m_last, busy});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release s_ready=%b busy=%b required 1/0", s_ready, busy);
        end
`ifdef REFLECT_FRAME_CNT_EN
        checks++;
        if (frame_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_frame_cnt got=%0d required=0", frame_cnt);
        end
`endif
    endtask

    task automatic test_pass();
        fill_frame(0);
        send_frame(2'b00, 0, N, 2'b00);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL pass_busy got=%b required=1", busy); end
        collect(N, 0);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL pass_latency got=%0d required=2", lat); end
        for (int i = 0; i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== 8'(i) || got_eol[i] !== (i % C == C - 1) || got_last[i] !== (i == N - 1)) begin
                failures++;
                $display("FAIL pass_pix%0d got=%0d/%b/%b required=%0d/%b/%b", i, got_data[i], got_eol[i],
                         got_last[i], i, (i % C == C - 1), (i == N - 1));
            end
        end
        checks++;
        if (sready_hi != 0 || idle_flags != 0) begin
            failures++;
            $display("FAIL pass_drain_flags sready_hi=%0d idle_flags=%0d required 0/0", sready_hi, idle_flags);
        end
    endtask

    task automatic test_hflip();
        fill_frame(0);
        send_frame(2'b10, 0, N, 2'b10);
        collect(N, 0);
        for (int i = 0; i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== ref_pix(2'b10, i) || got_last[i] !== (i == N - 1)) begin
                failures++;
                $display("FAIL hflip_pix%0d got=%0d/%b required=%0d/%b", i, got_data[i], got_last[i],
                         ref_pix(2'b10, i), (i == N - 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] mds [2];
        mds[0] = 2'b01;
        mds[1] = 2'b11;
        fill_frame(0);
        for (int f = 0; f < 2; f++) begin
            send_frame(mds[f], 0, N, mds[f]);
            collect(N, 0);
            for (int i = 0; i < got_data.size(); i++) begin
                checks++;
                if (got_data[i] !== ref_pix(mds[f], i) || got_eol[i] !== (i % C == C - 1)) begin
                    failures++;
                    $display("FAIL b2b_f%0d_pix%0d got=%0d/%b required=%0d/%b", f, i, got_data[i], got_eol[i],
                             ref_pix(mds[f], i), (i % C == C - 1));
                end
            end
            checks++;
            if (sready_hi != 0) begin failures++; $display("FAIL b2b_sready_in_drain got=%0d required=0", sready_hi); end
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL b2b_return_idle s_ready=%b busy=%b required 1/0", s_ready, busy);
            end
        end
    endtask

    task automatic test_mode_change();
        fill_frame(1);
        send_frame(2'b10, 0, 5, 2'b01);
        collect(N, 0);
        for (int i = 0; i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== ref_pix(2'b10, i)) begin
                failures++;
                $display("FAIL modechg_pix%0d got=%0d required=%0d", i, got_data[i], ref_pix(2'b10, i));
            end
        end
    endtask

    task automatic test_stall();
        for (int f = 0; f < 4; f++) begin
            logic [1:0] md;
            md = 2'($urandom_range(3));
            fill_frame(1);
            send_frame(md, 30, N, md);
            collect(N, 50);
            checks++;
            if (lat !== 2 || unstable != 0 || idle_flags != 0 || got_data.size() != N) begin
                failures++;
                $display("FAIL stall_f%0d lat=%0d unstable=%0d idle_flags=%0d n=%0d required 2/0/0/%0d",
                         f, lat, unstable, idle_flags, got_data.size(), N);
            end
            for (int i = 0; i < got_data.size(); i++) begin
                checks++;
                if (got_data[i] !== ref_pix(md, i) || got_last[i] !== (i == N - 1)) begin
                    failures++;
                    $display("FAIL stall_f%0d_pix%0d got=%0d/%b required=%0d/%b", f, i, got_data[i],
                             got_last[i], ref_pix(md, i), (i == N - 1));
                end
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        fill_frame(1);
        send_frame(2'b01, 0, N, 2'b01);
        collect(6, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, m_valid, m_data, m_eol, m_last, busy} !== 13'd0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h required=0", {s_ready, m_valid, m_data, m_eol, m_last, busy});
        end
`ifdef REFLECT_FRAME_CNT_EN
        checks++;
        if (frame_cnt !== 16'd0) begin failures++; $display("FAIL midreset_frame_cnt got=%0d required=0", frame_cnt); end
`endif
        m_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL midreset_sready got=%b required=1", s_ready); end
        fill_frame(1);
        send_frame(2'b11, 0, N, 2'b11);
        collect(N, 0);
        for (int i = 0; i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== ref_pix(2'b11, i)) begin
                failures++;
                $display("FAIL midreset_pix%0d got=%0d required=%0d", i, got_data[i], ref_pix(2'b11, i));
            end
        end
        @(negedge clk);
`ifdef REFLECT_FRAME_CNT_EN
        checks++;
        if (frame_cnt !== 16'd1) begin failures++; $display("FAIL midreset_frame_cnt_after got=%0d required=1", frame_cnt); end
`endif
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL midreset_idle busy=%b required=0", busy); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_hflip();
        test_back_to_back();
        test_mode_change();
        test_stall();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
